// File: rtl/sha_round_ctrl_if.sv
// Handshake and control bundle between the block source, the round controller
// and the digest datapath.
// Ports: i_blk_vld/i_first/i_last/i_abort from upstream, o_blk_rdy back to it;
//        o_load/o_init/o_round_en/o_count/o_fin/o_done/o_busy/o_blk_cnt to the digest stage.
// The slave modport is the controller's view; master is the source/datapath view.
interface sha_round_ctrl_if;
  logic        i_blk_vld;
  logic        i_first;
  logic        i_last;
  logic        i_abort;
  logic        o_blk_rdy;
  logic        o_load;
  logic        o_init;
  logic        o_round_en;
  logic [6:0]  o_count;
  logic        o_fin;
  logic        o_done;
  logic        o_busy;
  logic [15:0] o_blk_cnt;

  modport slave (
    input  i_blk_vld, i_first, i_last, i_abort,
    output o_blk_rdy, o_load, o_init, o_round_en, o_count,
           o_fin, o_done, o_busy, o_blk_cnt
  );

  modport master (
    output i_blk_vld, i_first, i_last, i_abort,
    input  o_blk_rdy, o_load, o_init, o_round_en, o_count,
           o_fin, o_done, o_busy, o_blk_cnt
  );
endinterface

// File: rtl/sha_round_ctrl.sv
// Purpose: SHA-256 round sequencer: accepts 512-bit blocks, walks 64 rounds, finalises H.
// Latency: accept at T -> o_load T+1, rounds T+2..T+65, o_fin T+66, o_done T+67 (last block).
// Backpressure: o_blk_rdy only in IDLE/WAIT; i_stall (SHA_STALL_EN) freezes the round counter.
//
// Ports:
//   i_clk        single clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_stall      (only when SHA_STALL_EN is defined) hold the round counter during ROUND
//   bus          sha_round_ctrl_if.slave: block handshake in, schedule/digest controls out
// Optional feature macro: SHA_STALL_EN (default build: no stall input, ROUND is exactly 64 cycles).
module sha_round_ctrl (
  input  logic            i_clk,
  input  logic            i_rst,
`ifdef SHA_STALL_EN
  input  logic            i_stall,
`endif
  sha_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [6:0]  LAST_ROUND = 7'd63;
  localparam logic [6:0]  FIN_COUNT  = 7'd64;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t      r_state;
  logic        r_last;
  logic        r_blk_rdy;
  logic        r_load;
  logic        r_init;
  logic        r_round_en;
  logic        r_fin;
  logic        r_done;
  logic        r_busy;
  logic [6:0]  r_count;
  logic [15:0] r_blk_cnt;

  logic        w_accept;
  logic        w_step;
  logic        w_new_msg;
  logic [15:0] w_blk_cnt_inc;

  // r_blk_rdy is only ever high in IDLE/WAIT, so it doubles as the accept qualifier.
  assign w_accept  = bus.i_blk_vld & r_blk_rdy;

  // A block accepted from IDLE always starts a message; in WAIT only when i_first says so.
  assign w_new_msg = (r_state == IDLE) | bus.i_first;

  assign w_blk_cnt_inc = (r_blk_cnt == CNT_MAX) ? r_blk_cnt : r_blk_cnt + 16'd1;

`ifdef SHA_STALL_EN
  assign w_step = ~i_stall;
`else
  assign w_step = 1'b1;
`endif

  // All control outputs are registered next to the state so they change only on the
  // state transition; o_round_en is the one exception because a stall must drop it in
  // the same cycle it is asserted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b0;
      r_blk_rdy  <= 1'b1;
      r_load     <= 1'b0;
      r_init     <= 1'b0;
      r_round_en <= 1'b0;
      r_fin      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_count    <= 7'd0;
      r_blk_cnt  <= 16'd0;
    end else begin
      // single-cycle pulses default low
      r_load <= 1'b0;
      r_init <= 1'b0;
      r_fin  <= 1'b0;
      r_done <= 1'b0;

      if (bus.i_abort) begin
        // Abort wins over a simultaneous acceptance and drops the partial message.
        r_state    <= IDLE;
        r_blk_rdy  <= 1'b1;
        r_round_en <= 1'b0;
        r_busy     <= 1'b0;
        r_count    <= 7'd0;
        r_blk_cnt  <= 16'd0;
      end else begin
        case (r_state)
          IDLE, WAIT: begin
            if (w_accept) begin
              r_state   <= LOAD;
              r_last    <= bus.i_last;
              r_load    <= 1'b1;
              r_blk_rdy <= 1'b0;
              r_busy    <= 1'b1;
              r_count   <= 7'd0;
              if (w_new_msg) begin
                r_init    <= 1'b1;
                r_blk_cnt <= 16'd0;
              end
            end
          end

          LOAD: begin
            r_state    <= ROUND;
            r_round_en <= 1'b1;
            r_count    <= 7'd0;
          end

          ROUND: begin
            if (w_step) begin
              if (r_count == LAST_ROUND) begin
                r_state    <= FINAL;
                r_round_en <= 1'b0;
                r_count    <= FIN_COUNT;
                r_fin      <= 1'b1;
                r_blk_cnt  <= w_blk_cnt_inc;
              end else begin
                r_count <= r_count + 7'd1;
              end
            end
          end

          FINAL: begin
            r_count <= 7'd0;
            if (r_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= WAIT;
              r_blk_rdy <= 1'b1;
            end
          end

          DONE: begin
            // o_blk_cnt is left alone so the final count stays visible until the next o_init.
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_blk_rdy <= 1'b1;
          end

          default: begin
            r_state    <= IDLE;
            r_blk_rdy  <= 1'b1;
            r_round_en <= 1'b0;
            r_busy     <= 1'b0;
            r_count    <= 7'd0;
          end
        endcase
      end
    end
  end

  assign bus.o_blk_rdy  = r_blk_rdy;
  assign bus.o_load     = r_load;
  assign bus.o_init     = r_init;
  assign bus.o_round_en = r_round_en & w_step;
  assign bus.o_count    = r_count;
  assign bus.o_fin      = r_fin;
  assign bus.o_done     = r_done;
  assign bus.o_busy     = r_busy;
  assign bus.o_blk_cnt  = r_blk_cnt;

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Bench for sha_round_ctrl: randomized multi-block messages with aborts, restarts and
// an asynchronous reset, checked by a scoreboard of expected per-cycle output events.
module tb_sha_round_ctrl;

  logic clk;
  logic rst_n;
`ifdef SHA_STALL_EN
  logic stall;
`endif

  sha_round_ctrl_if bus();

  sha_round_ctrl dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
`ifdef SHA_STALL_EN
    .i_stall (stall),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // flags = {load, init, round_en, fin, done, busy, blk_rdy}
  typedef struct {
    int          cyc;
    logic [6:0]  flags;
    logic [6:0]  cnt;
    logic [15:0] blk;
    bit          chk_blk;
  } ev_t;

  ev_t q[$];

  // reference model state
  bit m_idle;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL missing_event: got none expected flags %b count %0d at cycle %0d (now %0d)",
                 q[0].flags, q[0].cnt, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (bus.o_load || bus.o_round_en || bus.o_fin || bus.o_done || bus.o_init) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_event: got load=%b init=%b rnd=%b fin=%b done=%b cnt=%0d expected idle (cycle %0d)",
                   bus.o_load, bus.o_init, bus.o_round_en, bus.o_fin, bus.o_done, bus.o_count, cyc);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("event_flags",
                {25'd0, bus.o_load, bus.o_init, bus.o_round_en, bus.o_fin, bus.o_done, bus.o_busy, bus.o_blk_rdy},
                {25'd0, e.flags});
          check("event_count", {25'd0, bus.o_count}, {25'd0, e.cnt});
          if (e.chk_blk)
            check("event_blk_cnt", {16'd0, bus.o_blk_cnt}, {16'd0, e.blk});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"},
          {25'd0, bus.o_load, bus.o_init, bus.o_round_en, bus.o_fin, bus.o_done, bus.o_busy, bus.o_blk_rdy},
          32'b0000001);
    check({tag, "_count"}, {25'd0, bus.o_count}, 32'd0);
    check({tag, "_blk_cnt"}, {16'd0, bus.o_blk_cnt}, 32'd0);
  endtask

  task automatic push_ev(input int c, input logic [6:0] f, input int cnt, input int blk, input bit cb);
    ev_t e;
    e.cyc = c; e.flags = f; e.cnt = 7'(cnt); e.blk = 16'(blk); e.chk_blk = cb;
    q.push_back(e);
  endtask

  task automatic check_idle_side(input string tag, input bit exp_busy);
    check({tag, "_rdy"}, {31'd0, bus.o_blk_rdy}, 32'd1);
    check({tag, "_busy"}, {31'd0, bus.o_busy}, {31'd0, exp_busy});
    check({tag, "_count"}, {25'd0, bus.o_count}, 32'd0);
    check({tag, "_blk_cnt"}, {16'd0, bus.o_blk_cnt}, 32'(m_cnt));
  endtask

  // Called at a negedge while the DUT is in IDLE/WAIT. killed=1 if the message ended early.
  task automatic do_block(input bit first, input bit last, input int abort_rnd,
                          input int rst_rnd, output bit killed);
    int  c;
    bit  init;
    killed = 1'b0;
    check_idle_side("present", !m_idle);
    c = cyc;
    bus.i_blk_vld = 1'b1;
    bus.i_first   = first;
    bus.i_last    = last;
    init = m_idle || first;
    if (init) m_cnt = 0;
    push_ev(c + 1, init ? 7'b1100010 : 7'b1000010, 0, 0, 1'b0);
    for (int k = 0; k < 64; k++) push_ev(c + 2 + k, 7'b0010010, k, 0, 1'b0);
    m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    push_ev(c + 66, 7'b0001010, 64, m_cnt, 1'b1);
    if (last) push_ev(c + 67, 7'b0000110, 0, m_cnt, 1'b1);
    @(negedge clk);
    bus.i_blk_vld = 1'b0;
    bus.i_first   = 1'b0;
    bus.i_last    = 1'b0;

    if (abort_rnd >= 0) begin
      repeat ((c + 2 + abort_rnd) - cyc) @(negedge clk);
      bus.i_abort = 1'b1;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc > cyc) q.delete(i);
      @(negedge clk);
      bus.i_abort = 1'b0;
      m_cnt  = 0;
      m_idle = 1'b1;
      check_idle_side("after_abort", 1'b0);
      killed = 1'b1;
    end else if (rst_rnd >= 0) begin
      repeat ((c + 2 + rst_rnd) - cyc) @(negedge clk);
      check("count_before_reset", {25'd0, bus.o_count}, 32'(rst_rnd));
      #2 rst_n = 1'b0;
      q.delete();
      #1 check_reset_vals("async_reset");
      @(negedge clk);
      rst_n  = 1'b1;
      m_cnt  = 0;
      m_idle = 1'b1;
      killed = 1'b1;
    end else begin
      repeat ((c + 67) - cyc) @(negedge clk);
      if (last) begin
        @(negedge clk);
        m_idle = 1'b1;
      end else begin
        m_idle = 1'b0;
      end
    end
  endtask

  // Block offered in WAIT together with abort: abort must win, no LOAD.
  task automatic abort_with_vld();
    check_idle_side("abort_vld_present", 1'b1);
    bus.i_blk_vld = 1'b1;
    bus.i_first   = 1'($urandom_range(0, 1));
    bus.i_last    = 1'($urandom_range(0, 1));
    bus.i_abort   = 1'b1;
    @(negedge clk);
    bus.i_blk_vld = 1'b0;
    bus.i_first   = 1'b0;
    bus.i_last    = 1'b0;
    bus.i_abort   = 1'b0;
    m_cnt  = 0;
    m_idle = 1'b1;
    check_idle_side("abort_vld_after", 1'b0);
  endtask

  initial begin
    bit killed;
    rst_n         = 1'b0;
    bus.i_blk_vld = 1'b0;
    bus.i_first   = 1'b0;
    bus.i_last    = 1'b0;
    bus.i_abort   = 1'b0;
`ifdef SHA_STALL_EN
    stall = 1'b0;
`endif
    m_idle = 1'b1;
    m_cnt  = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset_idle");

    for (int m = 0; m < 16; m++) begin
      int nblk, ab_blk, ab_rnd, rs_blk, rstart_blk, avld_blk;
      nblk = 1; ab_blk = -1; ab_rnd = 0; rs_blk = -1; rstart_blk = -1; avld_blk = -1;
      case (m)
        0: nblk = 1;
        1: nblk = 3;
        2: begin nblk = 3; ab_blk = 1; ab_rnd = 30; end
        3: begin nblk = 2; rs_blk = 0; end
        4: begin nblk = 3; rstart_blk = 1; end
        5: begin nblk = 3; avld_blk = 2; end
        default: begin
          nblk = $urandom_range(1, 3);
          if ($urandom_range(0, 4) == 0) begin
            ab_blk = $urandom_range(0, nblk - 1);
            ab_rnd = $urandom_range(0, 63);
          end
          if (nblk > 1 && $urandom_range(0, 3) == 0) rstart_blk = $urandom_range(1, nblk - 1);
          if (nblk > 1 && $urandom_range(0, 5) == 0) avld_blk = nblk - 1;
        end
      endcase
      for (int b = 0; b < nblk; b++) begin
        bit first;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (b == avld_blk) begin
          abort_with_vld();
          break;
        end
        first = (b == 0) ? 1'($urandom_range(0, 1)) : (b == rstart_blk);
        do_block(first, b == nblk - 1, (b == ab_blk) ? ab_rnd : -1,
                 (b == rs_blk) ? 40 : -1, killed);
        if (killed) break;
      end
      // final count holds in IDLE until the next message starts
      if (!killed && avld_blk < 0)
        check("idle_blk_cnt_hold", {16'd0, bus.o_blk_cnt}, 32'(m_cnt));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sha_round_ctrl.md
SHA_ROUND_CTRL -- requirements
Module: sha_round_ctrl

Interface
REQ-001 The block SHALL have port i_clk, input, 1, the single clock; all logic on posedge.
REQ-002 The block SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port i_blk_vld, input, 1, a 512-bit block is presented upstream.
REQ-004 The block SHALL have port i_first, input, 1, the presented block starts a new message; qualified by i_blk_vld.
REQ-005 The block SHALL have port i_last, input, 1, the presented block ends the message; qualified by i_blk_vld.
REQ-006 The block SHALL have port i_abort, input, 1, synchronous abort of the current message.
REQ-007 The block SHALL have port o_blk_rdy, output, 1, ready to accept a block.
REQ-008 The block SHALL have port o_load, output, 1, one-cycle pulse: load message schedule from the accepted block.
REQ-009 The block SHALL have port o_init, output, 1, one-cycle pulse coincident with o_load: reset H0..H7 to the IV.
REQ-010 The block SHALL have port o_round_en, output, 1, compression round active this cycle.
REQ-011 The block SHALL have port o_count, output, 7, round index 0..64 driven to the digest stage.
REQ-012 The block SHALL have port o_fin, output, 1, one-cycle pulse with o_count=64: add working vars into H.
REQ-013 The block SHALL have port o_done, output, 1, one-cycle pulse: message digest final.
REQ-014 The block SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-015 The block SHALL have port o_blk_cnt, output, 16, blocks completed in the current message; saturates at 16'hFFFF.

Function
REQ-016 The block SHALL implement the FSM states IDLE, LOAD, ROUND, FINAL, WAIT, DONE.
REQ-017 o_blk_rdy SHALL be 1 only in IDLE and WAIT; a block is accepted in a cycle where i_blk_vld=1 and o_blk_rdy=1.
REQ-018 On acceptance the FSM SHALL enter LOAD next cycle; i_last SHALL be latched at acceptance.
REQ-019 In LOAD (exactly one cycle), o_load=1, o_count=0, and o_init=1 if the acceptance was from IDLE or had i_first=1.
REQ-020 In ROUND, o_round_en=1 and o_count SHALL step 0,1,...,63, one per cycle, for exactly 64 cycles.
REQ-021 In FINAL (one cycle), o_count=64, o_fin=1, and o_blk_cnt SHALL increment (saturating).
REQ-022 From FINAL the FSM SHALL go to DONE if the latched last=1, else to WAIT.
REQ-023 In DONE (one cycle), o_done=1; next state IDLE; o_blk_cnt holds until the next o_init.
REQ-024 On acceptance at cycle T: o_load at T+1, rounds at T+2..T+65, o_fin at T+66, o_done at T+67 for a last block.
REQ-025 An acceptance in WAIT with i_first=1 SHALL restart the message (o_init=1, o_blk_cnt cleared to 0 in LOAD).
REQ-026 o_count SHALL hold 0 in IDLE, WAIT and DONE.
REQ-027 i_abort=1 in any state SHALL force IDLE on the next edge, clear o_blk_cnt, and suppress o_fin/o_done; i_abort has priority over acceptance.
REQ-028 o_load, o_init, o_fin and o_done SHALL never be high for two consecutive cycles.

Reset
REQ-029 While i_rst=0, the FSM SHALL be IDLE and o_load, o_init, o_round_en, o_fin, o_done, o_busy=0, o_count=0, o_blk_cnt=0, o_blk_rdy=1.
REQ-030 Reset assertion mid-ROUND SHALL take effect immediately without waiting for a clock, and the block SHALL resume from IDLE after deassertion.

Configuration
REQ-031 With SHA_STALL_EN defined, an input i_stall (1 bit) SHALL exist; i_stall=1 in ROUND SHALL drive o_round_en=0 and hold o_count; other states are unaffected, and the LOAD-to-FINAL latency extends by the number of stalled ROUND cycles.
REQ-032 Without SHA_STALL_EN, no i_stall port SHALL exist and ROUND SHALL always last exactly 64 cycles.

Verification
REQ-033 Single block: i_blk_vld=1, i_first=1, i_last=1 at T -> o_init and o_load at T+1, o_count 0..63 at T+2..T+65, o_fin at T+66 with o_count=64, o_done at T+67, o_blk_cnt=1.
REQ-034 Three-block message -> exactly one o_init, three o_fin, one o_done, and o_blk_cnt=3; o_blk_rdy is high in WAIT between blocks.
REQ-035 i_abort at round 30 of block 2 -> IDLE next cycle, o_blk_cnt=0, no o_fin or o_done.
REQ-036 i_rst low at o_count=40 -> all outputs at reset values with no clock edge; a new message after release completes normally.
REQ-037 i_blk_vld in WAIT with i_first=1 -> o_init=1 in LOAD and o_blk_cnt restarts from 0.
REQ-038 With SHA_STALL_EN, i_stall high for 5 cycles at o_count=10 -> o_count held at 10, o_fin at T+71.
